// File: rtl/fifo_read_port_pkg.sv
// Shared definitions for the FIFO read port: output-stage occupancy states
// and the read-group width helper.
package fifo_read_port_pkg;

  typedef enum logic [1:0] {
    S0,
    S1,
    S2
  } occ_state_t;

  function automatic int group_width(input int bits, input int par_read);
    return bits * par_read;
  endfunction

endpackage

// File: rtl/fifo_out_stage.sv
// Two-entry registered output stage (head + skid) with a valid/ready
// handshake; reports whether it can take another group this cycle.
module fifo_out_stage
  import fifo_read_port_pkg::*;
#(
  parameter int GROUP_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               pop,
  input  logic               out_ready,
  input  logic [GROUP_W-1:0] din,
  output logic [GROUP_W-1:0] out_data,
  output logic               out_valid,
  output logic               can_accept
);

  occ_state_t         state;
  logic [GROUP_W-1:0] skid;
  logic               deq;

  assign deq        = out_valid & out_ready;
  assign can_accept = (state != S2) | deq;

  // out_valid is kept as its own register so it leaves the block flop-driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S0;
      out_data  <= '0;
      skid      <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= S0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S0: begin
          if (pop) begin
            out_data  <= din;
            out_valid <= 1'b1;
            state     <= S1;
          end
        end
        S1: begin
          if (pop && deq) begin
            out_data <= din;
          end else if (pop) begin
            skid  <= din;
            state <= S2;
          end else if (deq) begin
            out_valid <= 1'b0;
            state     <= S0;
          end
        end
        S2: begin
          if (deq) begin
            out_data <= skid;
            if (pop) begin
              skid <= din;
            end else begin
              state <= S1;
            end
          end
        end
        default: begin
          state     <= S0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_read_port.sv
// Read-side controller for the circular-buffer FIFO: pops one group per cycle
// into a registered output stage and counts popped groups.
module fifo_read_port
  import fifo_read_port_pkg::*;
#(
  parameter int PAR_READ = 1,
  parameter int BITS     = 16,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     empty,
  input  logic [BITS*PAR_READ-1:0] buf_dout,
  output logic                     cnt_r,
  input  logic                     flush,
  output logic [BITS*PAR_READ-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         rd_count
);

  localparam int GROUP_W = group_width(BITS, PAR_READ);

  logic can_accept;
  logic pop;

  // Reset is folded in so the datapath pointer never moves while held in reset.
  assign pop   = ~empty & ~flush & ~rst & can_accept;
  assign cnt_r = pop;

  fifo_out_stage #(
    .GROUP_W(GROUP_W)
  ) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .pop       (pop),
    .out_ready (out_ready),
    .din       (buf_dout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .can_accept(can_accept)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
    end else if (pop) begin
      rd_count <= rd_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_read_port.sv
// Randomized and directed bench for fifo_read_port, checked against a
// queue-based model of the datapath and the two-entry output stage.
module tb_fifo_read_port;

  localparam int BITS     = 16;
  localparam int PAR_READ = 1;
  localparam int CNT_W    = 4;
  localparam int GW       = BITS * PAR_READ;

  logic          clk = 1'b0;
  logic          rst;
  logic          empty;
  logic [GW-1:0] buf_dout;
  logic          cnt_r;
  logic          flush;
  logic [GW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CNT_W-1:0] rd_count;

  int checks   = 0;
  int failures = 0;

  logic [GW-1:0] dp_q[$];
  logic [GW-1:0] model_q[$];
  int            model_cnt = 0;

  fifo_read_port #(
    .PAR_READ(PAR_READ),
    .BITS    (BITS),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .empty    (empty),
    .buf_dout (buf_dout),
    .cnt_r    (cnt_r),
    .flush    (flush),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rd_count (rd_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at negedge, compare against the model, then let
  // the datapath queue advance on the edge if the DUT strobed cnt_r.
  task automatic applyStimulus(input logic r, input logic f, input logic rdy);
    logic          exp_pop;
    logic          deq;
    logic          obs_pop;
    logic [GW-1:0] word;
    @(negedge clk);
    rst       = r;
    flush     = f;
    out_ready = rdy;
    empty     = (dp_q.size() == 0);
    buf_dout  = empty ? '0 : dp_q[0];
    #1;
    checkOutput("out_valid", out_valid, model_q.size() > 0);
    if (model_q.size() > 0) checkOutput("out_data", out_data, model_q[0]);
    checkOutput("rd_count", rd_count, model_cnt % (1 << CNT_W));
    deq     = (model_q.size() > 0) && rdy;
    exp_pop = !r && !f && (dp_q.size() > 0) && ((model_q.size() < 2) || deq);
    checkOutput("cnt_r", cnt_r, exp_pop);
    obs_pop = cnt_r;
    word    = buf_dout;
    if (r) begin
      model_q.delete();
      model_cnt = 0;
    end else if (f) begin
      model_q.delete();
    end else begin
      if (deq) void'(model_q.pop_front());
      if (exp_pop) begin
        model_q.push_back(word);
        model_cnt++;
      end
    end
    @(posedge clk);
    if (r) dp_q.delete();
    else if (obs_pop && dp_q.size() > 0) void'(dp_q.pop_front());
  endtask

  task automatic pushRange(input int first, input int last);
    for (int v = first; v <= last; v++) dp_q.push_back(GW'(v));
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    empty     = 1'b0;
    buf_dout  = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_data", out_data, 16'h0000);
    checkOutput("reset_out_valid", out_valid, 1'b0);

    // Reset held with a non-empty datapath
    pushRange(16'h0050, 16'h0053);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);

    // Streaming
    pushRange(1, 8);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b1);
    #1 checkOutput("stream_count", rd_count, 8);

    // Stall then release
    applyStimulus(1'b1, 1'b0, 1'b0);
    pushRange(1, 4);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
    #1 checkOutput("stall_pops", rd_count, 2);
    checkOutput("stall_head", out_data, 16'h0001);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b1);

    // Empty boundary
    dp_q.push_back(16'h00AA);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);

    // Flush with head and skid occupied
    applyStimulus(1'b1, 1'b0, 1'b0);
    pushRange(1, 3);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);

    // Counter wrap
    applyStimulus(1'b1, 1'b0, 1'b1);
    pushRange(16'h0100, 16'h0110);
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b1);
    #1 checkOutput("wrap_count", rd_count, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int n;
      n = $urandom_range(0, 3);
      if (n < 3) for (int k = 0; k < n; k++) dp_q.push_back(GW'($urandom));
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
